// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with frame-level debounce,
// one-cycle key_valid pulse and a 4-digit shift register of accepted codes.
module keypad_scan #(
    parameter int SCAN_DIV = 4000,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  col_in,
    output logic [3:0]  row_out,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] num_out
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);
    // nibble {r,c} holds the hex code of the key at row r, column c
    localparam logic [63:0] MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;
    state_t state, state_nx;

    logic [3:0]    sync1, col_s;
    logic [DW-1:0] div;
    logic [1:0]    r;
    logic          tick, frame_end;
    logic [2:0]    low_cnt, sum;
    logic [1:0]    col_idx, hits, f_hits;
    logic [3:0]    row_code, code_acc, f_code;
    logic [3:0]    cand, cand_nx;
    logic [CW-1:0] cnt, cnt_nx, rcnt, rcnt_nx;
    logic          single, none, accept;

    assign tick      = div == DW'(SCAN_DIV - 1);
    assign frame_end = tick && r == 2'd3;
    assign row_out   = ~(4'b0001 << r);
    assign key_held  = state == HELD;

    assign low_cnt  = {2'b0, ~col_s[0]} + {2'b0, ~col_s[1]} + {2'b0, ~col_s[2]} + {2'b0, ~col_s[3]};
    assign col_idx  = !col_s[0] ? 2'd0 : !col_s[1] ? 2'd1 : !col_s[2] ? 2'd2 : 2'd3;
    assign row_code = MAP[{r, col_idx, 2'b00} +: 4];
    assign sum      = {1'b0, hits} + low_cnt;
    assign f_hits   = sum > 3'd1 ? 2'd2 : sum[1:0];
    assign f_code   = hits == 2'd0 ? row_code : code_acc;
    assign single   = f_hits == 2'd1;
    assign none     = f_hits == 2'd0;

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        rcnt_nx  = rcnt;
        accept   = 1'b0;
        if (frame_end) begin
            case (state)
                IDLE: if (single) begin
                    cand_nx = f_code;
                    cnt_nx  = CW'(1);
                    if (DEBOUNCE == 1) begin
                        accept   = 1'b1;
                        state_nx = HELD;
                        rcnt_nx  = '0;
                    end else begin
                        state_nx = PRESS;
                    end
                end
                PRESS: if (!single) begin
                    state_nx = IDLE;
                end else if (f_code != cand) begin
                    cand_nx = f_code;
                    cnt_nx  = CW'(1);
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt_nx == CW'(DEBOUNCE)) begin
                        accept   = 1'b1;
                        state_nx = HELD;
                        rcnt_nx  = '0;
                    end
                end
                HELD: if (none) begin
                    rcnt_nx  = rcnt + 1'b1;
                    state_nx = rcnt_nx == CW'(DEBOUNCE) ? IDLE : HELD;
                end else begin
                    rcnt_nx = '0;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 4'b1111;
            col_s     <= 4'b1111;
            div       <= '0;
            r         <= 2'd0;
            hits      <= 2'd0;
            code_acc  <= 4'd0;
            state     <= IDLE;
            cand      <= 4'd0;
            cnt       <= '0;
            rcnt      <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'd0;
            num_out   <= 16'h0000;
        end else begin
            sync1     <= col_in;
            col_s     <= sync1;
            div       <= tick ? '0 : div + 1'b1;
            r         <= tick ? r + 2'd1 : r;
            hits      <= tick ? (frame_end ? 2'd0 : f_hits) : hits;
            code_acc  <= tick && !frame_end ? f_code : code_acc;
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            rcnt      <= rcnt_nx;
            key_valid <= accept;
            key_code  <= accept ? cand_nx : key_code;
            num_out   <= accept ? {num_out[11:0], cand_nx} : num_out;
        end
    end
endmodule
